// File: rtl/shift_reg_pkg.sv
// Shared types and sizing helper for the parallel-in/serial-out shift register.
package shift_reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // A single-lane word still needs a one-bit counter so the ports stay legal.
  function automatic int cnt_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_serializer.sv
// Unloads one Width*Ratio word as Ratio Width-bit beats with valid/ready on both sides
// and reloads on the final beat's handshake so consecutive words have no bubble.
module shift_reg_serializer
  import shift_reg_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned Ratio    = 4,
  parameter bit          MsbFirst = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [Width*Ratio-1:0] data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [Width-1:0]       data_o,
  output logic                   last_o
);

  localparam int CntWidth = cnt_width(Ratio);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(Ratio - 1);

  ser_state_e                 r_state, w_state_next;
  logic [CntWidth-1:0]        r_cnt, w_cnt_next;
  logic [Width*Ratio-1:0]     r_buf, w_buf_next;

  logic                       w_valid;
  logic                       w_last;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_out_hs;
  logic [CntWidth-1:0]        w_lane;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_buf   <= w_buf_next;
    end
  end

  // ready_o depends combinationally on ready_i and flush_i so the last beat can reload.
  always_comb begin
    w_valid      = (r_state == SHIFT);
    w_last       = w_valid && (r_cnt == LastCnt);
    w_ready      = !flush_i && ((r_state == IDLE) || (w_valid && ready_i && w_last));
    w_accept     = valid_i && w_ready;
    w_out_hs     = w_valid && ready_i;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_buf_next   = r_buf;

    if (flush_i) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else if (w_accept) begin
      w_state_next = SHIFT;
      w_cnt_next   = '0;
      w_buf_next   = data_i;
    end else if (w_out_hs) begin
      if (w_last) begin
        w_state_next = IDLE;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  assign w_lane  = MsbFirst ? (LastCnt - r_cnt) : r_cnt;
  assign data_o  = r_buf[int'(w_lane)*Width +: Width];
  assign valid_o = w_valid;
  assign last_o  = w_last;
  assign ready_o = w_ready;

`ifndef SYNTHESIS
  a_ratio_min : assert property (@(posedge clk_i) Ratio >= 1);

  a_last_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    last_o |-> valid_o);

  a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o) && $stable(last_o)));
`endif

endmodule
